// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
//   Write-only I2C slave receiver. SCL/SDA are oversampled on clk, START,
//   repeated START and STOP are detected, the 7-bit address is matched
//   against SLAVE_ADDR, and the address plus every data byte is ACKed.
//   NUM_BYTE bytes are assembled into one word and presented with a
//   single-cycle rx_valid pulse. Read requests and extra bytes are NACKed.
//
// Ports
//   clk        system clock (>= 8x SCL rate)
//   rst        asynchronous active-low reset
//   i2c_SCL_i  SCL line value
//   i2c_SDA_i  SDA line value
//   i2c_SDA_w  SDA output enable (1 = drive)
//   i2c_SDA_o  SDA drive value (always 0)
//   rx_valid   one-cycle pulse, rx_data holds a complete transaction
//   rx_data    received word, first byte on the bus in the top byte
//   rx_err     one-cycle pulse, transaction aborted by STOP/START
//   busy       high from a matched address until STOP
//   state_o    current FSM state (debug)
//
// Handshake: rx_valid is a pure strobe with no ready; the consumer must take
//   rx_data in the cycle rx_valid is high (rx_data also holds until the next
//   complete transaction).
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0011010,
  parameter int         NUM_BYTE   = 4,
  parameter int         BYTE_SIZE  = 8,
  parameter int         DATA_WIDTH = NUM_BYTE * BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_SCL_i,
  input  logic                  i2c_SDA_i,
  output logic                  i2c_SDA_w,
  output logic                  i2c_SDA_o,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_err,
  output logic                  busy,
  output logic [2:0]            state_o
);

  localparam int BCW = $clog2(BYTE_SIZE);
  localparam int NCW = $clog2(NUM_BYTE + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BYTE_SIZE - 1);
  localparam logic [NCW-1:0] BYTE_LAST = NCW'(NUM_BYTE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_DATA      = 3'd3,
    S_DATA_ACK  = 3'd4,
    S_WAIT_STOP = 3'd5
  } state_e;

  // Input conditioning: two synchronizer flops plus one history flop each.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= i2c_SCL_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= i2c_SDA_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q &  scl_h_q;
  assign sda_rise  =  sda_s2_q & ~sda_h_q;
  assign sda_fall  = ~sda_s2_q &  sda_h_q;
  // SCL must be stably high across the SDA edge for a bus condition.
  assign start_det = sda_fall & scl_s2_q & scl_h_q;
  assign stop_det  = sda_rise & scl_s2_q & scl_h_q;

  state_e                state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [NCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [BYTE_SIZE-2:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  sda_w_q, sda_w_d;
  logic                  ack_hold_q, ack_hold_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_err_q, rx_err_d;
  logic                  busy_q, busy_d;

  // Byte including the bit being sampled this cycle.
  logic [BYTE_SIZE-1:0] byte_in;
  assign byte_in = {shift_q, sda_s2_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      rx_data_q  <= '0;
      sda_w_q    <= 1'b0;
      ack_hold_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      rx_data_q  <= rx_data_d;
      sda_w_q    <= sda_w_d;
      ack_hold_q <= ack_hold_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    rx_data_d  = rx_data_q;
    sda_w_d    = sda_w_q;
    ack_hold_d = ack_hold_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    busy_d     = busy_q;

    if (start_det || stop_det) begin
      // Bus conditions override whatever the FSM was doing.
      if (state_q == S_ADDR_ACK || state_q == S_DATA || state_q == S_DATA_ACK)
        rx_err_d = 1'b1;
      state_d    = start_det ? S_ADDR : S_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      word_d     = '0;
      sda_w_d    = 1'b0;
      ack_hold_d = 1'b0;
      if (stop_det) busy_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in[BYTE_SIZE-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (byte_in[BYTE_SIZE-1 -: 7] == SLAVE_ADDR && !byte_in[0]) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (scl_rise) begin
            shift_d = byte_in[BYTE_SIZE-2:0];
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              // Bytes arrive in order, so shifting left leaves the first
              // byte in the top position once the word is full.
              word_d  = (word_q << BYTE_SIZE) | DATA_WIDTH'(byte_in);
              state_d = S_DATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        // ACK: first SCL fall after the 8th bit grabs SDA, the next fall
        // (after the ACK clock high phase) releases it.
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_hold_q) begin
              sda_w_d    = 1'b1;
              ack_hold_d = 1'b1;
            end else begin
              sda_w_d    = 1'b0;
              ack_hold_d = 1'b0;
              if (state_q == S_ADDR_ACK) begin
                state_d = S_DATA;
              end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q == BYTE_LAST) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = word_q;
                  state_d    = S_WAIT_STOP;
                end else begin
                  state_d = S_DATA;
                end
              end
            end
          end
        end

        S_WAIT_STOP: ;

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign i2c_SDA_w = sda_w_q;
  assign i2c_SDA_o = 1'b0;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_err    = rx_err_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx
//   Directed bench for i2c_slave_rx. A behavioural I2C master drives SCL and
//   an open-drain SDA (wired-AND with the slave) at 16 clk per SCL period.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int Q = 4; // clk per quarter SCL period

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // bus
  logic scl_m, sda_m, sda_line;
  logic        i2c_SDA_w, i2c_SDA_o, rx_valid, rx_err, busy;
  logic [31:0] rx_data;
  logic [2:0]  state_o;

  assign sda_line = sda_m & ~(i2c_SDA_w & ~i2c_SDA_o);

  i2c_slave_rx dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_SCL_i (scl_m),
    .i2c_SDA_i (sda_line),
    .i2c_SDA_w (i2c_SDA_w),
    .i2c_SDA_o (i2c_SDA_o),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .busy      (busy),
    .state_o   (state_o)
  );

  // bookkeeping
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int drive_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  data_buf [0:7];
  logic        ack_buf  [0:8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("rx_valid_spurious", 64'(rx_valid), 64'd0);
      else                   check("rx_data_sb", 64'(rx_data), 64'(exp_q.pop_front()));
    end
    if (rx_err)    err_cnt++;
    if (i2c_SDA_w) drive_cnt++;
  end

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
    end
  endtask

  task automatic ack_slot(output logic a);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    a = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic xfer(input logic [7:0] addr_byte, input int n, input bit do_stop);
    logic a;
    i2c_start();
    send_bits(addr_byte);
    ack_slot(a);
    ack_buf[0] = a;
    for (int i = 0; i < n; i++) begin
      send_bits(data_buf[i]);
      ack_slot(a);
      ack_buf[i+1] = a;
    end
    if (do_stop) i2c_stop();
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [7:0] ADDR_W  = {7'b0011010, 1'b0};
  localparam logic [7:0] ADDR_R  = {7'b0011010, 1'b1};
  localparam logic [7:0] ADDR_BAD = {7'b0011011, 1'b0};

  initial begin
    int v0, e0, d0;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sda_w",    64'(i2c_SDA_w), 64'd0);
    check("rst_sda_o",    64'(i2c_SDA_o), 64'd0);
    check("rst_rx_valid", 64'(rx_valid),  64'd0);
    check("rst_rx_data",  64'(rx_data),   64'd0);
    check("rst_rx_err",   64'(rx_err),    64'd0);
    check("rst_busy",     64'(busy),      64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    // nominal write 0xdeadbeef
    data_buf[0] = 8'hde; data_buf[1] = 8'had; data_buf[2] = 8'hbe; data_buf[3] = 8'hef;
    exp_q.push_back(32'hdeadbeef);
    v0 = valid_cnt;
    xfer(ADDR_W, 4, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("nom_ack%0d", i), 64'(ack_buf[i]), 64'd0);
    check("nom_busy_before_stop", 64'(busy), 64'd1);
    check("nom_rx_data", 64'(rx_data), 64'h0000_0000_dead_beef);
    i2c_stop();
    check("nom_busy_after_stop", 64'(busy), 64'd0);
    check("nom_valid_pulses", 64'(valid_cnt - v0), 64'd1);

    // back-to-back writes
    e0 = err_cnt; v0 = valid_cnt;
    data_buf[0] = 8'hab; data_buf[1] = 8'hcd; data_buf[2] = 8'hab; data_buf[3] = 8'hcd;
    exp_q.push_back(32'habcdabcd);
    xfer(ADDR_W, 4, 1'b1);
    data_buf[0] = 8'h11; data_buf[1] = 8'h11; data_buf[2] = 8'h11; data_buf[3] = 8'h11;
    exp_q.push_back(32'h11111111);
    xfer(ADDR_W, 4, 1'b1);
    check("b2b_valid_pulses", 64'(valid_cnt - v0), 64'd2);
    check("b2b_no_err", 64'(err_cnt - e0), 64'd0);
    check("b2b_rx_data", 64'(rx_data), 64'h1111_1111);

    // address mismatch
    d0 = drive_cnt; v0 = valid_cnt;
    data_buf[0] = 8'h55; data_buf[1] = 8'haa; data_buf[2] = 8'h55; data_buf[3] = 8'haa;
    xfer(ADDR_BAD, 4, 1'b0);
    check("mis_addr_nack", 64'(ack_buf[0]), 64'd1);
    check("mis_busy", 64'(busy), 64'd0);
    i2c_stop();
    check("mis_never_driven", 64'(drive_cnt - d0), 64'd0);
    check("mis_no_valid", 64'(valid_cnt - v0), 64'd0);

    // early STOP after two bytes
    e0 = err_cnt; v0 = valid_cnt;
    data_buf[0] = 8'hde; data_buf[1] = 8'had;
    xfer(ADDR_W, 2, 1'b1);
    check("early_ack1", 64'(ack_buf[1]), 64'd0);
    check("early_ack2", 64'(ack_buf[2]), 64'd0);
    check("early_err_pulse", 64'(err_cnt - e0), 64'd1);
    check("early_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("early_rx_data_held", 64'(rx_data), 64'h1111_1111);
    check("early_busy", 64'(busy), 64'd0);

    // read request
    xfer(ADDR_R, 0, 1'b0);
    check("read_nack", 64'(ack_buf[0]), 64'd1);
    check("read_busy", 64'(busy), 64'd0);
    i2c_stop();

    // overflow: 5-byte write
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) data_buf[i] = 8'(i + 1);
    exp_q.push_back(32'h01020304);
    xfer(ADDR_W, 5, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("ovf_ack%0d", i), 64'(ack_buf[i]), 64'd0);
    check("ovf_byte5_nack", 64'(ack_buf[5]), 64'd1);
    check("ovf_rx_data", 64'(rx_data), 64'h0102_0304);
    i2c_stop();
    check("ovf_valid_pulses", 64'(valid_cnt - v0), 64'd1);

    // reset asserted while the slave is driving the address ACK
    i2c_start();
    send_bits(ADDR_W);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    check("mrst_ack_driven", 64'(i2c_SDA_w), 64'd1);
    rst = 1'b0;
    #1;
    check("mrst_sda_released", 64'(i2c_SDA_w), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_rx_data", 64'(rx_data), 64'd0);
    wait_q();
    rst = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
    i2c_stop();

    // recovery after reset
    v0 = valid_cnt;
    data_buf[0] = 8'h12; data_buf[1] = 8'h34; data_buf[2] = 8'h56; data_buf[3] = 8'h78;
    exp_q.push_back(32'h12345678);
    xfer(ADDR_W, 4, 1'b1);
    check("rec_valid_pulses", 64'(valid_cnt - v0), 64'd1);
    check("rec_rx_data", 64'(rx_data), 64'h1234_5678);

    // final report
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    check("total_err_pulses", 64'(err_cnt), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
